// File: rtl/decoder_pl_pkg.sv
// Shared NewHope message-codec definitions: modulus, centre point, decoder FSM
// encoding and the message-bit placement used by both encoder and decoder.
package decoder_pl_pkg;

    localparam logic [15:0] NEWHOPE_Q = 16'd12289;
    localparam logic [15:0] HALF_Q    = 16'd6144;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        FETCH_B = 3'd2,
        ACC     = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Bit index inside a big-endian [0:31] message word for byte byte_idx, bit bit_idx (LSB=0).
    function automatic logic [4:0] msg_bit_pos(input logic [1:0] byte_idx, input logic [2:0] bit_idx);
        return {byte_idx, 3'd7 - bit_idx};
    endfunction

endpackage

// File: rtl/newhope_flipabs.sv
// Distance of a coefficient from Q/2: |x - HALF_Q|, defined for every 16-bit input.
module newhope_flipabs
    import decoder_pl_pkg::*;
(
    input  logic [15:0] x,
    output logic [15:0] y
);

    logic signed [16:0] r;
    logic signed [16:0] r_neg;

    assign r     = $signed({1'b0, x}) - $signed({1'b0, HALF_Q});
    assign r_neg = -r;
    assign y     = r[16] ? r_neg[15:0] : r[15:0];

endmodule

// File: rtl/decoder_pl.sv
// NewHope message decoder: reads 512 coefficients, decides 256 bits from pairs (k, k+256)
// and writes 8 big-endian words. Optional sticky range check under DECODER_RANGE_CHECK_EN.
module decoder_pl
    import decoder_pl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    output logic [8:0]  poly_addrb,
    input  logic [15:0] poly_dob,
    output logic        msg_we,
    output logic [2:0]  msg_addr,
    output logic [0:31] msg_di,
    output logic        range_err
);

    state_t      state, state_nxt;
    logic [7:0]  k;
    logic [0:31] word_buf;
    logic [15:0] a_abs;
    logic [15:0] flip;
    logic [16:0] sum;
    logic        bit_val;
    logic        we_nxt;
    logic        done_nxt;

    // One flipabs serves both coefficients: k is seen in FETCH_B, k+256 in ACC.
    newhope_flipabs u_flipabs (
        .x (poly_dob),
        .y (flip)
    );

    assign sum     = {1'b0, a_abs} + {1'b0, flip};
    assign bit_val = (sum < {1'b0, HALF_Q});

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH_A;
            FETCH_A: state_nxt = FETCH_B;
            FETCH_B: state_nxt = ACC;
            ACC:     state_nxt = (k[4:0] == 5'd31) ? WRITE : FETCH_A;
            WRITE:   state_nxt = (k == 8'd255) ? DONE : FETCH_A;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        poly_addrb = 9'd0;
        we_nxt     = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            FETCH_A: poly_addrb = {1'b0, k};
            FETCH_B: poly_addrb = {1'b1, k};
            WRITE:   we_nxt     = 1'b1;
            DONE:    done_nxt   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= 8'd0;
            word_buf <= '0;
            a_abs    <= 16'd0;
            msg_we   <= 1'b0;
            msg_addr <= 3'd0;
            msg_di   <= '0;
            done     <= 1'b0;
        end else begin
            msg_we <= we_nxt;
            done   <= done_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        k        <= 8'd0;
                        word_buf <= '0;
                    end
                end
                FETCH_B: a_abs <= flip;
                ACC: begin
                    word_buf[msg_bit_pos(k[4:3], k[2:0])] <= bit_val;
                    if (k[4:0] != 5'd31) k <= k + 8'd1;
                end
                WRITE: begin
                    msg_addr <= k[7:5];
                    msg_di   <= word_buf;
                    word_buf <= '0;
                    if (k != 8'd255) k <= k + 8'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef DECODER_RANGE_CHECK_EN
    // Sticky until the next accepted start; decoding itself is unaffected.
    always_ff @(posedge clk) begin
        if (rst)
            range_err <= 1'b0;
        else if (state == IDLE && start)
            range_err <= 1'b0;
        else if ((state == FETCH_B || state == ACC) && poly_dob >= NEWHOPE_Q)
            range_err <= 1'b1;
    end
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_pl.sv
// Scoreboard bench for decoder_pl: directed coefficient images, expected words queued
// at stimulus time and compared by a monitor on every msg_we.
module tb_decoder_pl;
    import decoder_pl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic [8:0]  poly_addrb;
    logic [15:0] poly_dob;
    logic        msg_we;
    logic [2:0]  msg_addr;
    logic [0:31] msg_di;
    logic        range_err;
    logic [31:0] di_int;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem [0:511];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          we_cnt = 0;
    int          done_cnt = 0;

    decoder_pl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .done       (done),
        .poly_addrb (poly_addrb),
        .poly_dob   (poly_dob),
        .msg_we     (msg_we),
        .msg_addr   (msg_addr),
        .msg_di     (msg_di),
        .range_err  (range_err)
    );

    always #5 clk = ~clk;

    // Coefficient RAM with one cycle of read latency.
    always @(posedge clk) poly_dob <= mem[poly_addrb];

    assign di_int = msg_di;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic push(input logic [2:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_const(input logic [31:0] d);
        for (int w = 0; w < 8; w++) push(3'(w), d);
    endtask

    task automatic fill_all(input logic [15:0] v);
        for (int i = 0; i < 512; i++) mem[i] = v;
    endtask

    // Monitor: every write is checked against the head of the scoreboard.
    always @(negedge clk) begin
        if (msg_we) begin
            we_cnt++;
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: addr %0d data %h, no write was queued", msg_addr, di_int);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("msg_addr", {29'd0, msg_addr}, {29'd0, e.addr});
                check("msg_di", di_int, e.data);
            end
        end
        if (done) done_cnt++;
    end

    // Full decode; restart_at pulses start mid-run to confirm it is ignored.
    task automatic run_decode(input logic exp_rerr, input int restart_at);
        int n;
        we_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 1;
        check("range_err_cleared", {31'd0, range_err}, 32'd0);
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
            start = (n == restart_at);
        end
        start = 1'b0;
        check("done_seen", {31'd0, done}, 32'd1);
        check("done_cycle", n - 1, 32'd777);
        check("range_err_at_done", {31'd0, range_err}, {31'd0, exp_rerr});
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("we_count", we_cnt, 32'd8);
        check("sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic exp_rerr;
        rst   = 1'b1;
        start = 1'b0;
        fill_all(16'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_msg_we", {31'd0, msg_we}, 32'd0);
        check("rst_msg_addr", {29'd0, msg_addr}, 32'd0);
        check("rst_msg_di", di_int, 32'd0);
        check("rst_poly_addrb", {23'd0, poly_addrb}, 32'd0);
        check("rst_range_err", {31'd0, range_err}, 32'd0);
        rst = 1'b0;

        // All at Q/2: every bit 1.
        fill_all(HALF_Q);
        push_const(32'hFFFF_FFFF);
        run_decode(1'b0, -1);

        // All zero and all Q-1: every bit 0.
        fill_all(16'd0);
        push_const(32'h0000_0000);
        run_decode(1'b0, -1);
        fill_all(16'd12288);
        push_const(32'h0000_0000);
        run_decode(1'b0, -1);

        // Threshold at k=0: sum 6144 decides 0 (msg_di[7] = integer bit 24).
        fill_all(HALF_Q);
        mem[0]   = 16'd9216;
        mem[256] = 16'd9216;
        push(3'd0, 32'hFEFF_FFFF);
        for (int w = 1; w < 8; w++) push(3'(w), 32'hFFFF_FFFF);
        run_decode(1'b0, -1);
        // Sum 6143 decides 1.
        mem[0] = 16'd9215;
        push_const(32'hFFFF_FFFF);
        run_decode(1'b0, -1);

        // Round trip: encode bytes 0x00..0x1F, add +/-3000 noise, expect original bytes back.
        for (int k = 0; k < 256; k++) begin
            int bv;
            int cv;
            int nz;
            bv = ((k >> 3) >> (k & 7)) & 1;
            cv = bv ? 6144 : 0;
            nz = (k % 2 == 1) ? -3000 : 3000;
            mem[k]       = 16'((cv + 12289 + nz) % 12289);
            mem[k + 256] = 16'((cv + 12289 - nz) % 12289);
        end
        for (int w = 0; w < 8; w++) begin
            logic [7:0] b0, b1, b2, b3;
            b0 = 8'(4 * w);
            b1 = 8'(4 * w + 1);
            b2 = 8'(4 * w + 2);
            b3 = 8'(4 * w + 3);
            push(3'(w), {b0, b1, b2, b3});
        end
        run_decode(1'b0, 50);

        // Reset at cycle 400: words 0..3 already written, nothing after, no done.
        fill_all(HALF_Q);
        for (int w = 0; w < 4; w++) push(3'(w), 32'hFFFF_FFFF);
        we_cnt = 0;
        d0 = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int n = 2; n <= 400; n++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (1000) @(negedge clk);
        check("rst_mid_we_count", we_cnt, 32'd4);
        check("rst_mid_no_done", done_cnt, d0);
        check("rst_mid_sb_empty", sb.size(), 32'd0);
        // Fresh decode after the abort.
        push_const(32'hFFFF_FFFF);
        run_decode(1'b0, -1);

        // Out-of-range coefficient 300 (k=44 hi): bit 44 = byte 5 bit 4 -> word 1 integer bit 20.
        fill_all(HALF_Q);
        mem[300] = 16'd12289;
        push(3'd0, 32'hFFFF_FFFF);
        push(3'd1, 32'hFFEF_FFFF);
        for (int w = 2; w < 8; w++) push(3'(w), 32'hFFFF_FFFF);
`ifdef DECODER_RANGE_CHECK_EN
        exp_rerr = 1'b1;
`else
        exp_rerr = 1'b0;
`endif
        run_decode(exp_rerr, -1);
        check("range_err_held", {31'd0, range_err}, {31'd0, exp_rerr});
        // Next start clears it.
        fill_all(HALF_Q);
        push_const(32'hFFFF_FFFF);
        run_decode(1'b0, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
